// File: rtl/reg_file_sb.sv
// Multi-ported register file with optional write-to-read bypass and a
// per-register pending-write scoreboard for the control FSM's stall logic.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [DATA_W-1:0]       rd_data_a,
    output logic [DATA_W-1:0]       rd_data_b,
    output logic                    rd_busy_a,
    output logic                    rd_busy_b,
    input  logic                    wr0_en,
    input  logic [ADDR_W-1:0]       wr0_addr,
    input  logic [DATA_W-1:0]       wr0_data,
    input  logic                    wr1_en,
    input  logic [ADDR_W-1:0]       wr1_addr,
    input  logic [DATA_W-1:0]       wr1_data,
    input  logic                    claim_en,
    input  logic [ADDR_W-1:0]       claim_addr,
    output logic [(2**ADDR_W)-1:0]  busy_vec,
    output logic                    wr_collision
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              collision_q, collision_d;

    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        regs_d      = regs_q;
        busy_d      = busy_q;
        collision_d = wr0_en && wr1_en && (wr0_addr == wr1_addr);
        for (int i = 0; i < NREGS; i++) begin
            // Port 1 is applied first so port 0 overwrites it on a collision.
            if (wr1_en && (wr1_addr == ADDR_W'(i))) begin
                regs_d[i] = wr1_data;
                busy_d[i] = 1'b0;
            end
            if (wr0_en && (wr0_addr == ADDR_W'(i))) begin
                regs_d[i] = wr0_data;
                busy_d[i] = 1'b0;
            end
            // A same-cycle claim marks a new producer, so it beats the clear.
            if (claim_en && (claim_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // NOTE: the array is held in flops rather than a RAM macro because it
    // must clear on reset and support two writes plus two reads per cycle.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from the values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q      <= '{default: '0};
            busy_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            collision_q <= collision_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs_q[addr];
        if (BYPASS) begin
            if (wr1_en && (wr1_addr == addr)) val = wr1_data;
            if (wr0_en && (wr0_addr == addr)) val = wr0_data;
        end
        return val;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

    // Busy reflects registered state only; a same-cycle write does not clear it.
    assign rd_busy_a    = busy_q[rd_addr_a];
    assign rd_busy_b    = busy_q[rd_addr_b];
    assign busy_vec     = busy_q;
    assign wr_collision = collision_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic
// against an array-based reference model; also covers BYPASS=0 and a 16x8 build.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 16;
    localparam int SDW = 16;
    localparam int SAW = 3;
    localparam int SNR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr0_addr, wr1_addr, claim_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_en, wr1_en, claim_en;
    logic [DW-1:0] rd_data_a, rd_data_b, nb_data_a, nb_data_b;
    logic          rd_busy_a, rd_busy_b, nb_busy_a, nb_busy_b;
    logic [NR-1:0] busy_vec, nb_busy_vec;
    logic          wr_collision, nb_collision;

    logic           s_rst, s_wr0_en, s_wr1_en, s_claim_en;
    logic [SAW-1:0] s_rd_addr_a, s_rd_addr_b, s_wr0_addr, s_wr1_addr, s_claim_addr;
    logic [SDW-1:0] s_wr0_data, s_wr1_data, s_rd_data_a, s_rd_data_b;
    logic           s_busy_a, s_busy_b, s_collision;
    logic [SNR-1:0] s_busy_vec;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy_vec(busy_vec), .wr_collision(wr_collision)
    );

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nb_data_a), .rd_data_b(nb_data_b),
        .rd_busy_a(nb_busy_a), .rd_busy_b(nb_busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy_vec(nb_busy_vec), .wr_collision(nb_collision)
    );

    reg_file_sb #(.DATA_W(SDW), .ADDR_W(SAW), .BYPASS(1'b1)) dut_small (
        .clk(clk), .rst(s_rst),
        .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
        .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
        .rd_busy_a(s_busy_a), .rd_busy_b(s_busy_b),
        .wr0_en(s_wr0_en), .wr0_addr(s_wr0_addr), .wr0_data(s_wr0_data),
        .wr1_en(s_wr1_en), .wr1_addr(s_wr1_addr), .wr1_data(s_wr1_data),
        .claim_en(s_claim_en), .claim_addr(s_claim_addr),
        .busy_vec(s_busy_vec), .wr_collision(s_collision)
    );

    // Reference model: architectural register contents and pending flags.
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;
    logic          m_coll;
    logic [SDW-1:0] s_model [SNR];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] addr, input bit bypass);
        if (bypass && wr0_en && wr0_addr == addr) return wr0_data;
        if (bypass && wr1_en && wr1_addr == addr) return wr1_data;
        return m_regs[addr];
    endfunction

    task automatic idle();
        rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; claim_en = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_busy = '0;
        m_coll = 1'b0;
    endtask

    // Entered just after a falling edge with inputs driven; checks the
    // combinational outputs, advances the model, then moves to the next falling edge.
    task automatic step(input string tag);
        #1;
        check({tag, ".rda"}, 64'(rd_data_a), 64'(exp_read(rd_addr_a, 1'b1)));
        check({tag, ".rdb"}, 64'(rd_data_b), 64'(exp_read(rd_addr_b, 1'b1)));
        check({tag, ".nba"}, 64'(nb_data_a), 64'(exp_read(rd_addr_a, 1'b0)));
        check({tag, ".nbb"}, 64'(nb_data_b), 64'(exp_read(rd_addr_b, 1'b0)));
        check({tag, ".bsya"}, 64'(rd_busy_a), 64'(m_busy[rd_addr_a]));
        check({tag, ".bsyb"}, 64'(rd_busy_b), 64'(m_busy[rd_addr_b]));
        check({tag, ".bvec"}, 64'(busy_vec), 64'(m_busy));
        check({tag, ".coll"}, 64'(wr_collision), 64'(m_coll));
        if (rst) begin
            model_reset();
        end else begin
            m_coll = wr0_en && wr1_en && (wr0_addr == wr1_addr);
            if (wr1_en) begin m_regs[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
            if (wr0_en) begin m_regs[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
            if (claim_en) m_busy[claim_addr] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; s_rst = 1'b1;
        wr0_en = 0; wr1_en = 0; claim_en = 0;
        wr0_addr = '0; wr1_addr = '0; claim_addr = '0; wr0_data = '0; wr1_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        s_wr0_en = 0; s_wr1_en = 0; s_claim_en = 0;
        s_wr0_addr = '0; s_wr1_addr = '0; s_claim_addr = '0; s_wr0_data = '0; s_wr1_data = '0;
        s_rd_addr_a = '0; s_rd_addr_b = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        idle();
        s_rst = 1'b0;

        // Reset state across every address.
        for (int i = 0; i < NR; i++) begin
            rd_addr_a = AW'(i); rd_addr_b = AW'(NR - 1 - i);
            step("reset");
        end

        // Bypassed write to R3, then the stored value on the next cycle.
        rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        wr0_en = 1; wr0_addr = 4'd3; wr0_data = 32'hDEADBEEF;
        #1;
        check("r3_byp_now", 64'(rd_data_a), 64'h0000_0000_DEAD_BEEF);
        check("r3_nb_now", 64'(nb_data_a), 64'h0);
        step("wr_r3");
        idle();
        #1;
        check("r3_nb_next", 64'(nb_data_a), 64'h0000_0000_DEAD_BEEF);
        step("rd_r3");

        // Collision on R5: port 0 wins, pulse lasts exactly one cycle.
        wr0_en = 1; wr0_addr = 4'd5; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 4'd5; wr1_data = 32'h22;
        rd_addr_a = 4'd5;
        step("coll_wr");
        idle();
        #1;
        check("coll_pulse", 64'(wr_collision), 64'h1);
        check("coll_r5", 64'(rd_data_a), 64'h11);
        step("coll_1");
        step("coll_2");

        // Distinct addresses on both ports, no collision.
        wr0_en = 1; wr0_addr = 4'd1; wr0_data = 32'hA;
        wr1_en = 1; wr1_addr = 4'd2; wr1_data = 32'hB;
        rd_addr_a = 4'd1; rd_addr_b = 4'd2;
        step("dual_wr");
        idle();
        step("dual_rd");

        // Claim R7, clear it with a port-1 write, then claim+write together.
        claim_en = 1; claim_addr = 4'd7; rd_addr_a = 4'd7;
        step("claim7");
        idle();
        #1;
        check("claim7_busy", 64'(rd_busy_a), 64'h1);
        wr1_en = 1; wr1_addr = 4'd7; wr1_data = 32'h77;
        step("clr7_wr");
        idle();
        #1;
        check("clr7_busy", 64'(rd_busy_a), 64'h0);
        claim_en = 1; claim_addr = 4'd7; wr0_en = 1; wr0_addr = 4'd7; wr0_data = 32'h78;
        step("claim_wr7");
        idle();
        claim_en = 1; claim_addr = 4'd7;
        step("reclaim7");
        idle();
        step("hold7");

        // Mid-sequence reset overrides a same-cycle write and claims.
        for (int i = 1; i <= 4; i++) begin
            wr0_en = 1; wr0_addr = AW'(i); wr0_data = 32'h1000 + 32'(i);
            step("prefill");
        end
        idle();
        claim_en = 1; claim_addr = 4'd9;
        step("claim9");
        idle();
        rst = 1; wr0_en = 1; wr0_addr = 4'd2; wr0_data = 32'h5555;
        claim_en = 1; claim_addr = 4'd3;
        step("rst_mid");
        idle();
        for (int i = 0; i < NR; i++) begin
            rd_addr_a = AW'(i); rd_addr_b = AW'(i);
            step("post_rst");
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 39) == 0);
            wr0_en     = $urandom_range(0, 1);
            wr1_en     = $urandom_range(0, 1);
            claim_en   = ($urandom_range(0, 2) == 0);
            wr0_addr   = AW'($urandom_range(0, NR - 1));
            wr1_addr   = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, NR - 1));
            claim_addr = AW'($urandom_range(0, NR - 1));
            rd_addr_a  = AW'($urandom_range(0, NR - 1));
            rd_addr_b  = ($urandom_range(0, 4) == 0) ? rd_addr_a : AW'($urandom_range(0, NR - 1));
            wr0_data   = $urandom;
            wr1_data   = $urandom;
            step("rand");
        end
        idle();

        // 16-bit x 8 build: alternating, inverted and per-address patterns.
        for (int i = 0; i < SNR; i++) s_model[i] = '0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < SNR; i++) begin
                logic [SDW-1:0] v;
                case (p)
                    0:       v = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
                    1:       v = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
                    default: v = 16'h1111 * SDW'(i + 1);
                endcase
                s_wr0_en = 1; s_wr0_addr = SAW'(i); s_wr0_data = v;
                s_model[i] = v;
                @(posedge clk); @(negedge clk);
            end
            s_wr0_en = 0;
            for (int i = 0; i < SNR; i++) begin
                s_rd_addr_a = SAW'(i); s_rd_addr_b = SAW'(SNR - 1 - i);
                #1;
                check("small_a", 64'(s_rd_data_a), 64'(s_model[i]));
                check("small_b", 64'(s_rd_data_b), 64'(s_model[SNR - 1 - i]));
            end
        end
        check("small_bvec", 64'(s_busy_vec), 64'h0);
        check("small_coll", 64'(s_collision), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
